// File: rtl/drp_mux_pkg.sv
// Shared types and constants for the sequenced DRP fan-out mux.
// Local register offsets are counted down from the all-ones address.
package drp_mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [2:0] SEL_PORT_LO = 3'd0;
    localparam logic [2:0] SEL_PORT_HI = 3'd1;
    localparam logic [2:0] SEL_DRP_LO  = 3'd2;
    localparam logic [2:0] SEL_DRP_HI  = 3'd3;
    localparam logic [2:0] STATUS      = 3'd4;

    localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/drp_lsb_onehot.sv
// Lowest-set-bit isolator: keeps only the least significant 1 of vec.
module drp_lsb_onehot #(
    parameter int N = 2
) (
    input  logic [N-1:0] vec,
    output logic [N-1:0] onehot
);

    assign onehot = vec & (~vec + N'(1));

endmodule

// File: rtl/drp_mux_seq.sv
// Sequenced DRP fan-out from one upstream master to N quad DRP ports.
// One access outstanding; writes broadcast to selected quads, reads resolve to one quad.
module drp_mux_seq
    import drp_mux_pkg::*;
#(
    parameter int N           = 2,
    parameter int AW_QUAD     = 9,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   drp_clk,
    input  logic                   drp_rst_n,
    input  logic [AW_QUAD-1:0]     fpga_drpaddr,
    input  logic [DW-1:0]          fpga_drpdi,
    input  logic                   fpga_drpen,
    input  logic                   fpga_drpwe,
    output logic [DW-1:0]          fpga_drpdo,
    output logic                   fpga_drprdy,
    output logic [N*AW_QUAD-1:0]   quad_drpaddr,
    output logic [N*DW-1:0]        quad_drpdi,
    output logic [N-1:0]           quad_drpwe,
    output logic [N-1:0]           quad_drpen,
    output logic [N-1:0]           quad_int_reg,
    input  logic [N*DW-1:0]        quad_drpdo,
    input  logic [N-1:0]           quad_drprdy,
    output logic                   busy
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    state_t             state;
    logic [63:0]        drp_sel;
    logic [63:0]        port_sel;
    logic               timeout_sticky;
    logic               overlap_sticky;
    logic [N-1:0]       pending;
    logic [N-1:0]       en_r;
    logic [N-1:0]       int_r;
    logic [TW-1:0]      timer;
    logic [AW_QUAD-1:0] addr_r;
    logic [DW-1:0]      di_r;
    logic [DW-1:0]      do_r;
    logic               we_r;
    logic               rdy_r;

    logic [AW_QUAD-1:0] offset;
    logic [2:0]         reg_sel;
    logic               is_local;
    logic [N-1:0]       mask;
    logic [N-1:0]       mask_lsb;
    logic [N-1:0]       issue_set;
    logic [N-1:0]       hit;
    logic [N-1:0]       hit_lsb;
    logic [N-1:0]       pend_next;
    logic [DW-1:0]      local_rdata;
    logic [DW-1:0]      quad_rdata;

    drp_lsb_onehot #(.N(N)) u_target (
        .vec    (mask),
        .onehot (mask_lsb)
    );

    drp_lsb_onehot #(.N(N)) u_capture (
        .vec    (hit),
        .onehot (hit_lsb)
    );

    always_comb begin
        // Distance below the all-ones address; the top five codes are local.
        offset     = ~fpga_drpaddr;
        reg_sel    = offset[2:0];
        is_local   = (offset <= AW_QUAD'(STATUS));
        mask       = drp_sel[N-1:0] | port_sel[N-1:0];
        issue_set  = fpga_drpwe ? mask : mask_lsb;
        hit        = pending & quad_drprdy;
        pend_next  = pending & ~quad_drprdy;
        quad_rdata = '0;
        for (int i = 0; i < N; i++) begin
            quad_rdata = quad_rdata | (quad_drpdo[i*DW +: DW] & {DW{hit_lsb[i]}});
        end
        case (reg_sel)
            SEL_DRP_HI:  local_rdata = drp_sel[63:32];
            SEL_DRP_LO:  local_rdata = drp_sel[31:0];
            SEL_PORT_HI: local_rdata = port_sel[63:32];
            SEL_PORT_LO: local_rdata = port_sel[31:0];
            default:     local_rdata = {30'b0, overlap_sticky, timeout_sticky};
        endcase
    end

    always_ff @(posedge drp_clk) begin
        if (!drp_rst_n) begin
            state          <= IDLE;
            drp_sel        <= '0;
            port_sel       <= '0;
            timeout_sticky <= 1'b0;
            overlap_sticky <= 1'b0;
            pending        <= '0;
            en_r           <= '0;
            int_r          <= '0;
            timer          <= '0;
            addr_r         <= '0;
            di_r           <= '0;
            do_r           <= '0;
            we_r           <= 1'b0;
            rdy_r          <= 1'b0;
        end else begin
            rdy_r <= 1'b0;
            en_r  <= '0;
            if (fpga_drpen && state != IDLE) begin
                overlap_sticky <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (fpga_drpen && is_local) begin
                        state <= DONE;
                        rdy_r <= 1'b1;
                        if (!fpga_drpwe) begin
                            do_r <= local_rdata;
                        end else if (reg_sel == STATUS) begin
                            timeout_sticky <= timeout_sticky & ~fpga_drpdi[0];
                            overlap_sticky <= overlap_sticky & ~fpga_drpdi[1];
                        end else begin
                            // Any select write starts from an empty selection.
                            drp_sel  <= '0;
                            port_sel <= '0;
                            case (reg_sel)
                                SEL_DRP_HI:  drp_sel[63:32]  <= fpga_drpdi;
                                SEL_DRP_LO:  drp_sel[31:0]   <= fpga_drpdi;
                                SEL_PORT_HI: port_sel[63:32] <= fpga_drpdi;
                                default:     port_sel[31:0]  <= fpga_drpdi;
                            endcase
                        end
                    end else if (fpga_drpen) begin
                        if (mask == '0) begin
                            state <= DONE;
                            rdy_r <= 1'b1;
                            do_r  <= '0;
                        end else begin
                            addr_r  <= fpga_drpaddr;
                            di_r    <= fpga_drpdi;
                            we_r    <= fpga_drpwe;
                            pending <= issue_set;
                            int_r   <= port_sel[N-1:0] & issue_set;
                            en_r    <= issue_set;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    pending <= pend_next;
                    if ((|hit) && !we_r) begin
                        do_r <= quad_rdata;
                    end
                    // A response that empties pending beats a coincident timeout.
                    if (pend_next == '0) begin
                        state <= DONE;
                        rdy_r <= 1'b1;
                    end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                        state          <= DONE;
                        rdy_r          <= 1'b1;
                        do_r           <= TIMEOUT_DATA;
                        timeout_sticky <= 1'b1;
                        pending        <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign fpga_drpdo   = do_r;
    assign fpga_drprdy  = rdy_r;
    assign quad_drpaddr = {N{addr_r}};
    assign quad_drpdi   = {N{di_r}};
    assign quad_drpwe   = {N{we_r}};
    assign quad_drpen   = en_r;
    assign quad_int_reg = int_r;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_drp_mux_seq.sv
// Scoreboard bench for drp_mux_seq: reference model predicts strobes and completions,
// a monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_drp_mux_seq;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int TC = 20;

    localparam logic [AW-1:0] A_STAT    = 9'h1FB;
    localparam logic [AW-1:0] A_DRP_HI  = 9'h1FC;
    localparam logic [AW-1:0] A_DRP_LO  = 9'h1FD;
    localparam logic [AW-1:0] A_PORT_HI = 9'h1FE;
    localparam logic [AW-1:0] A_PORT_LO = 9'h1FF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     fpga_drpaddr = '0;
    logic [DW-1:0]     fpga_drpdi = '0;
    logic              fpga_drpen = 1'b0;
    logic              fpga_drpwe = 1'b0;
    logic [DW-1:0]     fpga_drpdo;
    logic              fpga_drprdy;
    logic [N*AW-1:0]   quad_drpaddr;
    logic [N*DW-1:0]   quad_drpdi;
    logic [N-1:0]      quad_drpwe;
    logic [N-1:0]      quad_drpen;
    logic [N-1:0]      quad_int_reg;
    logic [N*DW-1:0]   quad_drpdo = '0;
    logic [N-1:0]      quad_drprdy = '0;
    logic              busy;

    always #5 clk = ~clk;

    drp_mux_seq #(.N(N), .AW_QUAD(AW), .DW(DW), .TIMEOUT_CYC(TC)) dut (
        .drp_clk      (clk),
        .drp_rst_n    (rst_n),
        .fpga_drpaddr (fpga_drpaddr),
        .fpga_drpdi   (fpga_drpdi),
        .fpga_drpen   (fpga_drpen),
        .fpga_drpwe   (fpga_drpwe),
        .fpga_drpdo   (fpga_drpdo),
        .fpga_drprdy  (fpga_drprdy),
        .quad_drpaddr (quad_drpaddr),
        .quad_drpdi   (quad_drpdi),
        .quad_drpwe   (quad_drpwe),
        .quad_drpen   (quad_drpen),
        .quad_int_reg (quad_int_reg),
        .quad_drpdo   (quad_drpdo),
        .quad_drprdy  (quad_drprdy),
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] data;
        bit          chk;
    } rsp_t;

    typedef struct {
        logic [N-1:0]  en;
        logic [N-1:0]  intr;
        logic [AW-1:0] addr;
        logic [31:0]   di;
        logic          we;
    } stb_t;

    rsp_t rsp_q[$];
    stb_t stb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [63:0]  m_drp  = '0;
    logic [63:0]  m_port = '0;
    logic         m_to   = 1'b0;
    logic         m_ov   = 1'b0;
    logic [N-1:0] mute   = '0;
    int           dly_ovr [N];
    logic [31:0]  resp_val [N];
    int           cnt [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int first_set(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] local_val(input logic [AW-1:0] a);
        if (a == A_DRP_HI)  return m_drp[63:32];
        if (a == A_DRP_LO)  return m_drp[31:0];
        if (a == A_PORT_HI) return m_port[63:32];
        if (a == A_PORT_LO) return m_port[31:0];
        return {30'b0, m_ov, m_to};
    endfunction

    // Quad responder: answers each strobe after a delay, muted quads never answer.
    initial begin
        for (int q = 0; q < N; q++) begin
            cnt[q] = 0;
            dly_ovr[q] = 0;
            resp_val[q] = '0;
        end
        forever begin
            @(negedge clk);
            for (int q = 0; q < N; q++) begin
                quad_drprdy[q] = 1'b0;
                quad_drpdo[q*DW +: DW] = 32'hDEAD_0000 | q;
                if (cnt[q] > 0) begin
                    cnt[q]--;
                    if (cnt[q] == 0) begin
                        quad_drprdy[q] = 1'b1;
                        quad_drpdo[q*DW +: DW] = resp_val[q];
                    end
                end
                if (quad_drpen[q] && !mute[q])
                    cnt[q] = (dly_ovr[q] > 0) ? dly_ovr[q] : int'($urandom_range(1, 6));
            end
        end
    end

    // Monitor: pops expectations whenever the DUT strobes quads or completes upstream.
    rsp_t mon_r;
    stb_t mon_s;
    always @(negedge clk) begin
        if (fpga_drprdy) begin
            if (rsp_q.size() == 0) check("unexpected_fpga_drprdy", 1, 0);
            else begin
                mon_r = rsp_q.pop_front();
                if (mon_r.chk) check("fpga_drpdo", fpga_drpdo, mon_r.data);
            end
        end
        if (quad_drpen != '0) begin
            if (stb_q.size() == 0) check("unexpected_quad_drpen", quad_drpen, 0);
            else begin
                mon_s = stb_q.pop_front();
                check("quad_drpen", quad_drpen, mon_s.en);
                check("quad_int_reg", quad_int_reg, mon_s.intr);
                for (int i = 0; i < N; i++) begin
                    if (mon_s.en[i]) begin
                        check("quad_drpaddr", quad_drpaddr[i*AW +: AW], mon_s.addr);
                        check("quad_drpwe", quad_drpwe[i], mon_s.we);
                        if (mon_s.we) check("quad_drpdi", quad_drpdi[i*DW +: DW], mon_s.di);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [AW-1:0] a, input logic [31:0] d, input logic w,
                         output int exp_lat);
        rsp_t r;
        stb_t s;
        logic [N-1:0] msk;
        logic [N-1:0] pend;
        int q;
        check("busy_idle", busy, 0);
        r.chk = 1'b0;
        r.data = '0;
        exp_lat = -1;
        if (a >= A_STAT) begin
            exp_lat = 1;
            if (w) begin
                if (a == A_STAT) begin
                    if (d[0]) m_to = 1'b0;
                    if (d[1]) m_ov = 1'b0;
                end else begin
                    m_drp = '0;
                    m_port = '0;
                    if (a == A_DRP_HI) m_drp[63:32] = d;
                    else if (a == A_DRP_LO) m_drp[31:0] = d;
                    else if (a == A_PORT_HI) m_port[63:32] = d;
                    else m_port[31:0] = d;
                end
            end else begin
                r.chk = 1'b1;
                r.data = local_val(a);
            end
        end else begin
            msk = m_drp[N-1:0] | m_port[N-1:0];
            if (msk == '0) begin
                exp_lat = 1;
                r.chk = 1'b1;
                r.data = '0;
            end else begin
                q = first_set(msk);
                pend = w ? msk : (N'(1) << q);
                s.en = pend;
                s.intr = m_port[N-1:0] & pend;
                s.addr = a;
                s.di = d;
                s.we = w;
                stb_q.push_back(s);
                if ((pend & mute) != '0) begin
                    exp_lat = TC + 2;
                    r.chk = 1'b1;
                    r.data = 32'hFFFF_FFFF;
                    m_to = 1'b1;
                end else if (!w) begin
                    r.chk = 1'b1;
                    r.data = resp_val[q];
                end
            end
        end
        rsp_q.push_back(r);
        fpga_drpaddr = a;
        fpga_drpdi = d;
        fpga_drpwe = w;
        fpga_drpen = 1'b1;
        @(negedge clk);
        fpga_drpen = 1'b0;
        check("busy_active", busy, 1);
    endtask

    task automatic wait_rdy(input int exp_lat, output int lat);
        lat = 1;
        while (!fpga_drprdy && lat < TC + 40) begin
            @(negedge clk);
            lat++;
        end
        if (!fpga_drprdy) check("fpga_drprdy_wait_expired", 0, 1);
        else if (exp_lat > 0) check("latency", lat, exp_lat);
        @(negedge clk);
        check("fpga_drprdy_single_pulse", fpga_drprdy, 0);
    endtask

    task automatic access(input logic [AW-1:0] a, input logic [31:0] d, input logic w);
        int e;
        int l;
        issue(a, d, w, e);
        wait_rdy(e, l);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fpga_drprdy"}, fpga_drprdy, 0);
        check({tag, "_fpga_drpdo"}, fpga_drpdo, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_quad_drpen"}, quad_drpen, 0);
        check({tag, "_quad_int_reg"}, quad_int_reg, 0);
        check({tag, "_quad_drpwe"}, quad_drpwe, 0);
        check({tag, "_quad_drpaddr"}, quad_drpaddr, 0);
        check({tag, "_quad_drpdi"}, |quad_drpdi, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        int lat;
        int op;
        logic [AW-1:0] loc_addr [5];
        logic [31:0] v;
        loc_addr[0] = A_DRP_HI;
        loc_addr[1] = A_DRP_LO;
        loc_addr[2] = A_PORT_HI;
        loc_addr[3] = A_PORT_LO;
        loc_addr[4] = A_STAT;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        access(A_STAT, 0, 1'b0);
        access(A_DRP_LO, 0, 1'b0);

        // Broadcast write; quad 2 answers 5 cycles after quad 0
        access(A_DRP_LO, 32'h5, 1'b1);
        dly_ovr[0] = 1;
        dly_ovr[2] = 6;
        issue(9'h010, 32'hABCD, 1'b1, e);
        wait_rdy(e, lat);
        check("rdy_after_slowest_quad", lat >= 8, 1);
        dly_ovr[0] = 0;
        dly_ovr[2] = 0;

        // Read resolves to lowest selected quad
        access(A_DRP_LO, 32'h6, 1'b1);
        resp_val[1] = 32'h1234;
        access(9'h020, 0, 1'b0);

        // Port select drives int_reg and clears drp_sel
        access(A_PORT_LO, 32'h8, 1'b1);
        resp_val[3] = 32'h5A5A_0003;
        access(9'h030, 0, 1'b0);
        access(A_DRP_LO, 0, 1'b0);
        access(A_PORT_LO, 0, 1'b0);

        // Timeout on read, then on a partially answered write
        access(A_DRP_LO, 32'h1, 1'b1);
        mute = 4'b0001;
        access(9'h040, 0, 1'b0);
        access(A_STAT, 0, 1'b0);
        access(A_STAT, 32'h1, 1'b1);
        access(A_STAT, 0, 1'b0);
        access(A_DRP_LO, 32'h3, 1'b1);
        mute = 4'b0010;
        access(9'h044, 32'h7777, 1'b1);
        access(A_STAT, 0, 1'b0);
        access(A_STAT, 32'h1, 1'b1);
        mute = '0;

        // Overlapping select write during WAIT is dropped and flagged
        access(A_DRP_LO, 32'h2, 1'b1);
        dly_ovr[1] = 8;
        resp_val[1] = 32'hCAFE_0001;
        issue(9'h050, 0, 1'b0, e);
        repeat (2) @(negedge clk);
        fpga_drpaddr = A_DRP_LO;
        fpga_drpdi = 32'hF;
        fpga_drpwe = 1'b1;
        fpga_drpen = 1'b1;
        m_ov = 1'b1;
        @(negedge clk);
        fpga_drpen = 1'b0;
        wait_rdy(-1, lat);
        dly_ovr[1] = 0;
        access(A_STAT, 0, 1'b0);
        access(A_DRP_LO, 0, 1'b0);
        access(A_STAT, 32'h2, 1'b1);
        access(A_STAT, 0, 1'b0);

        // Empty masks, including select bits at or above N
        access(A_DRP_LO, 0, 1'b1);
        access(9'h060, 0, 1'b0);
        access(9'h061, 32'h1111, 1'b1);
        access(A_DRP_HI, 32'hFFFF_0000, 1'b1);
        access(A_DRP_HI, 0, 1'b0);
        access(9'h062, 0, 1'b0);
        access(A_PORT_HI, 32'h8000_0001, 1'b1);
        access(A_PORT_HI, 0, 1'b0);
        access(A_DRP_LO, 32'hFFFF_FFF0, 1'b1);
        access(9'h063, 0, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 2) begin
                v = $urandom_range(0, 15);
                if ($urandom_range(0, 3) == 0) v = v | ($urandom & 32'hFFFF_FFF0);
                access(loc_addr[$urandom_range(0, 3)], v, 1'b1);
            end else if (op == 3) begin
                access(loc_addr[$urandom_range(0, 4)], 0, 1'b0);
            end else begin
                for (int q = 0; q < N; q++) resp_val[q] = $urandom;
                access(AW'($urandom_range(0, 32'h1FA)), $urandom, 1'($urandom_range(0, 1)));
            end
        end

        // Reset in the middle of a read; the late quad answer must be ignored
        access(A_DRP_LO, 32'h1, 1'b1);
        dly_ovr[0] = 10;
        issue(9'h070, 0, 1'b0, e);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        rsp_q.delete();
        m_drp = '0;
        m_port = '0;
        m_to = 1'b0;
        m_ov = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("midreset");
        repeat (15) @(negedge clk);
        dly_ovr[0] = 0;
        check("busy_after_late_rdy", busy, 0);
        access(A_DRP_LO, 0, 1'b0);
        access(A_PORT_LO, 0, 1'b0);
        access(A_DRP_LO, 32'h4, 1'b1);
        resp_val[2] = 32'h0BAD_F00D;
        access(9'h071, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_rsp_drained", rsp_q.size(), 0);
        check("scoreboard_stb_drained", stb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
